// File: rtl/branch_predictor_if.sv
// Fetch/execute bus of the branch predictor.
// master: pipeline side (drives lookup PC and resolved-branch updates).
// slave:  predictor side (returns prediction and redirect request).
interface branch_predictor_if #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64
);
    localparam int IDX = $clog2(ENTRIES);

    // Fetch-stage lookup
    logic [XLEN-1:0] pc_f;
    logic            pred_taken_f;
    logic [XLEN-1:0] pred_target_f;
    logic [IDX-1:0]  pred_idx_f;

    // Execute-stage resolution
    logic            upd_valid_e;
    logic [XLEN-1:0] upd_pc_e;
    logic [XLEN-1:0] upd_target_e;
    logic [IDX-1:0]  upd_idx_e;
    logic            upd_taken_e;
    logic            upd_jump_e;
    logic            pred_taken_e;
    logic [XLEN-1:0] pred_target_e;
    logic            mispredict_e;
    logic [XLEN-1:0] redirect_pc_e;

    modport master (
        output pc_f,
        input  pred_taken_f, pred_target_f, pred_idx_f,
        output upd_valid_e, upd_pc_e, upd_target_e, upd_idx_e,
        output upd_taken_e, upd_jump_e, pred_taken_e, pred_target_e,
        input  mispredict_e, redirect_pc_e
    );

    modport slave (
        input  pc_f,
        output pred_taken_f, pred_target_f, pred_idx_f,
        input  upd_valid_e, upd_pc_e, upd_target_e, upd_idx_e,
        input  upd_taken_e, upd_jump_e, pred_taken_e, pred_target_e,
        output mispredict_e, redirect_pc_e
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Lookup is combinational from the registered tables; updates are written
// at the rising edge from the execute stage.
// Optional macro BP_GSHARE_EN: XOR the lookup index with a global history
// register (IDX bits, shifted with each resolved conditional branch).
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2
) (
    input logic                 clk,
    input logic                 rst,    // asynchronous, active low
    branch_predictor_if.slave   bus
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

    // Per-entry state. Counters and valid bits need a reset; tag, target
    // and jump bit are only meaningful behind a set valid bit.
    logic [CTR_W-1:0]   ctrReg    [ENTRIES];
    logic [ENTRIES-1:0] validReg;
    logic [TAG_W-1:0]   tagMem    [ENTRIES];
    logic [XLEN-1:0]    targetMem [ENTRIES];
    logic [ENTRIES-1:0] jumpReg;

    logic [IDX-1:0]     lookupIdx;
    logic               lookupHit;
    logic               lookupTaken;
    logic [XLEN-1:0]    fetchPlus4;

    logic [IDX-1:0]     updIdx;
    logic [TAG_W-1:0]   updTag;
    logic               updHit;
    logic               updWrite;
    logic [CTR_W-1:0]   ctrBase;
    logic [CTR_W-1:0]   ctrNext;
    logic [ENTRIES-1:0] entryWe;

`ifdef BP_GSHARE_EN
    logic [IDX-1:0]     ghrReg;

    // Global history: shift in the outcome of every resolved conditional branch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghrReg <= '0;
        end else if (bus.upd_valid_e && !bus.upd_jump_e) begin
            ghrReg <= {ghrReg[IDX-2:0], bus.upd_taken_e};
        end
    end

    assign lookupIdx = bus.pc_f[IDX+1:2] ^ ghrReg;
`else
    assign lookupIdx = bus.pc_f[IDX+1:2];
`endif

    // ---------------- Fetch-stage lookup ----------------
    assign fetchPlus4  = bus.pc_f + XLEN'(4);
    assign lookupHit   = validReg[lookupIdx] &&
                         (tagMem[lookupIdx] == bus.pc_f[XLEN-1:IDX+2]);
    assign lookupTaken = lookupHit &&
                         (jumpReg[lookupIdx] || ctrReg[lookupIdx][CTR_W-1]);

    assign bus.pred_idx_f    = lookupIdx;
    assign bus.pred_taken_f  = lookupTaken;
    assign bus.pred_target_f = lookupTaken ? targetMem[lookupIdx] : fetchPlus4;

    // ---------------- Execute-stage update ----------------
    assign updIdx = bus.upd_idx_e;
    assign updTag = bus.upd_pc_e[XLEN-1:IDX+2];
    assign updHit = validReg[updIdx] && (tagMem[updIdx] == updTag);

    // A not-taken outcome for a branch we are not tracking never allocates.
    assign updWrite = bus.upd_valid_e &&
                      (bus.upd_taken_e || bus.upd_jump_e || updHit);

    // A freshly allocated entry starts from the weakly-not-taken point so
    // one taken outcome makes it weakly taken.
    assign ctrBase = updHit ? ctrReg[updIdx] : CTR_WNT;

    // Saturating counter step; jumps pin the counter at its maximum
    always_comb begin
        ctrNext = ctrBase;
        if (bus.upd_jump_e) begin
            ctrNext = CTR_MAX;
        end else if (bus.upd_taken_e) begin
            if (ctrBase != CTR_MAX) ctrNext = ctrBase + CTR_W'(1);
        end else begin
            if (ctrBase != '0) ctrNext = ctrBase - CTR_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : gEntryWe
            assign entryWe[gi] = updWrite && (updIdx == IDX'(gi));
        end
    endgenerate

    // Counters and valid bits: cleared at once by reset, written on update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validReg <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctrReg[i] <= CTR_WNT;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (entryWe[i]) begin
                    ctrReg[i]   <= ctrNext;
                    validReg[i] <= 1'b1;
                end
            end
        end
    end

    // Tag/target/jump payload; a write during reset is invisible because
    // the valid bit stays clear
    always_ff @(posedge clk) begin
        if (updWrite) begin
            tagMem[updIdx]    <= updTag;
            targetMem[updIdx] <= bus.upd_target_e;
            jumpReg[updIdx]   <= bus.upd_jump_e;
        end
    end

    // ---------------- Redirect ----------------
    assign bus.mispredict_e  = bus.upd_valid_e &&
                               ((bus.pred_taken_e != bus.upd_taken_e) ||
                                (bus.upd_taken_e && (bus.pred_target_e != bus.upd_target_e)));
    assign bus.redirect_pc_e = bus.upd_taken_e ? bus.upd_target_e
                                               : bus.upd_pc_e + XLEN'(4);
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (ENTRIES=16, CTR_W=2).
// Expected values are queued as stimulus is driven and drained when the
// combinational outputs are sampled on the falling edge.
module tb_branch_predictor;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;

    logic clk;
    logic rst;

    branch_predictor_if #(.XLEN(XLEN), .ENTRIES(ENTRIES)) bpIf ();

    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bpIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {S_TAKEN, S_TARGET, S_IDX, S_MISP, S_REDIR} sel_e;
    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] value;
    } exp_t;

    exp_t sbQ[$];
    int   checkCount = 0;
    int   errCount   = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [31:0] getObs(input sel_e s);
        case (s)
            S_TAKEN:  return 32'(bpIf.pred_taken_f);
            S_TARGET: return bpIf.pred_target_f;
            S_IDX:    return 32'(bpIf.pred_idx_f);
            S_MISP:   return 32'(bpIf.mispredict_e);
            default:  return bpIf.redirect_pc_e;
        endcase
    endfunction

    task automatic pushExp(input string tag, input sel_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.sel = s; e.value = v;
        sbQ.push_back(e);
    endtask

    task automatic drainQ();
        exp_t e;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkVal(e.tag, getObs(e.sel), e.value);
        end
    endtask

    // Sample away from the active edge, then move just past the next one
    task automatic cycle();
        @(negedge clk);
        drainQ();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                         input logic [31:0] utgt, input logic ut, input logic uj,
                         input logic pt, input logic [31:0] ptgt);
        logic [31:0] u;
        u = upc;
        bpIf.pc_f          = pc;
        bpIf.upd_valid_e   = uv;
        bpIf.upd_pc_e      = upc;
        bpIf.upd_target_e  = utgt;
        bpIf.upd_idx_e     = u[5:2];
        bpIf.upd_taken_e   = ut;
        bpIf.upd_jump_e    = uj;
        bpIf.pred_taken_e  = pt;
        bpIf.pred_target_e = ptgt;
    endtask

    task automatic lookup(input logic [31:0] pc);
        drive(pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        lookup(32'h40);
        pushExp("rst_taken", S_TAKEN, 32'd0);
        pushExp("rst_target", S_TARGET, 32'h44);
        cycle();
        rst = 1'b1;

`ifdef BP_GSHARE_EN
        lookup(32'h40);
        pushExp("gs_idx0", S_IDX, 32'h0);
        cycle();
        for (int i = 0; i < 2; i++) begin
            drive(32'h40, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0, 1'b0, 32'h44);
            pushExp("gs_upd_misp", S_MISP, 32'd1);
            cycle();
        end
        lookup(32'h40);
        pushExp("gs_idx3", S_IDX, 32'h3);
        cycle();
`else
        // Fresh table
        lookup(32'h40);
        pushExp("init_taken", S_TAKEN, 32'd0);
        pushExp("init_target", S_TARGET, 32'h44);
        pushExp("init_idx", S_IDX, 32'h0);
        pushExp("idle_misp", S_MISP, 32'd0);
        cycle();

        // First taken update: same-cycle lookup still sees the old entry
        drive(32'h40, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0, 1'b0, 32'h44);
        pushExp("alloc_old_taken", S_TAKEN, 32'd0);
        pushExp("alloc_misp", S_MISP, 32'd1);
        pushExp("alloc_redir", S_REDIR, 32'h100);
        cycle();

        // Three correctly predicted taken updates (counter 2 -> 3 -> 3 -> 3)
        for (int i = 0; i < 3; i++) begin
            drive(32'h40, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0, 1'b1, 32'h100);
            pushExp($sformatf("tk%0d_taken", i), S_TAKEN, 32'd1);
            pushExp($sformatf("tk%0d_target", i), S_TARGET, 32'h100);
            pushExp($sformatf("tk%0d_misp", i), S_MISP, 32'd0);
            pushExp($sformatf("tk%0d_redir", i), S_REDIR, 32'h100);
            cycle();
        end

        // Two not-taken updates (3 -> 2 -> 1)
        drive(32'h40, 1'b1, 32'h40, 32'h100, 1'b0, 1'b0, 1'b1, 32'h100);
        pushExp("nt0_taken", S_TAKEN, 32'd1);
        pushExp("nt0_misp", S_MISP, 32'd1);
        pushExp("nt0_redir", S_REDIR, 32'h44);
        cycle();
        drive(32'h40, 1'b1, 32'h40, 32'h100, 1'b0, 1'b0, 1'b1, 32'h100);
        pushExp("nt1_taken", S_TAKEN, 32'd1);
        pushExp("nt1_target", S_TARGET, 32'h100);
        cycle();
        lookup(32'h40);
        pushExp("ctr1_taken", S_TAKEN, 32'd0);
        pushExp("ctr1_target", S_TARGET, 32'h44);
        cycle();

        // Jump at 0x80 replaces the entry at index 0
        drive(32'h80, 1'b1, 32'h80, 32'h200, 1'b1, 1'b1, 1'b0, 32'h84);
        pushExp("jmp_old_taken", S_TAKEN, 32'd0);
        pushExp("jmp_misp", S_MISP, 32'd1);
        pushExp("jmp_redir", S_REDIR, 32'h200);
        cycle();
        lookup(32'h80);
        pushExp("jmp_taken", S_TAKEN, 32'd1);
        pushExp("jmp_target", S_TARGET, 32'h200);
        pushExp("jmp_idx", S_IDX, 32'h0);
        cycle();
        lookup(32'h480);
        pushExp("alias_taken", S_TAKEN, 32'd0);
        pushExp("alias_target", S_TARGET, 32'h484);
        cycle();

        // Not-taken update with a tag mismatch must not allocate
        drive(32'h80, 1'b1, 32'h480, 32'h900, 1'b0, 1'b0, 1'b0, 32'h484);
        pushExp("nalloc_misp", S_MISP, 32'd0);
        pushExp("nalloc_redir", S_REDIR, 32'h484);
        cycle();
        lookup(32'h80);
        pushExp("nalloc_taken", S_TAKEN, 32'd1);
        pushExp("nalloc_target", S_TARGET, 32'h200);
        cycle();

        // Same-cycle lookup/update: old target now, new target next cycle
        drive(32'h80, 1'b1, 32'h80, 32'h300, 1'b1, 1'b1, 1'b1, 32'h200);
        pushExp("same_old_target", S_TARGET, 32'h200);
        pushExp("same_misp_tgt", S_MISP, 32'd1);
        pushExp("same_redir", S_REDIR, 32'h300);
        cycle();
        lookup(32'h80);
        pushExp("same_new_target", S_TARGET, 32'h300);
        cycle();

        // Index decode at the top of the table
        lookup(32'h3C);
        pushExp("idx_top", S_IDX, 32'hF);
        pushExp("idx_top_target", S_TARGET, 32'h40);
        cycle();

        // Reset pulsed low between edges clears predictions immediately
        drive(32'h80, 1'b1, 32'h80, 32'h300, 1'b0, 1'b0, 1'b1, 32'h300);
        #1 rst = 1'b0;
        #1;
        pushExp("mrst_taken", S_TAKEN, 32'd0);
        pushExp("mrst_target", S_TARGET, 32'h84);
        pushExp("mrst_misp", S_MISP, 32'd1);
        pushExp("mrst_redir", S_REDIR, 32'h84);
        drainQ();
        #1 rst = 1'b1;
        cycle();
        lookup(32'h80);
        pushExp("post_rst_taken", S_TAKEN, 32'd0);
        pushExp("post_rst_target", S_TARGET, 32'h84);
        cycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
        $finish;
    end
endmodule
